// File: rtl/logisim_uart_pkg.sv
// Shared types and frame arithmetic for the logisim UART transmitter.
// Used by the RTL and by the testbench.
package logisim_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  function automatic int frame_cycles(input int data_w, input int parity_en,
                                      input int clks_per_bit);
    return (2 + data_w + parity_en) * clks_per_bit;
  endfunction

endpackage

// File: rtl/logisim_bit_timer.sv
// Baud timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick on the
// last cycle of each bit. Clears whenever disabled or in reset.
module logisim_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = en & w_last;

  always_ff @(posedge CLK) begin
    if (!RST || !en || w_last)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/logisim_uart_tx.sv
// Valid/ready UART transmitter: start bit, DATA_W bits LSB first, optional
// even parity, stop bit. TX is registered from the next-state values.
module logisim_uart_tx
  import logisim_uart_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] D,
  input  logic              VALID,
  output logic              READY,
  output logic              TX,
  output logic              BUSY
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_t         r_state, w_state_next;
  logic [DATA_W-1:0] r_shift, w_shift_next;
  logic [BW-1:0]     r_bit_idx, w_bit_idx_next;
  logic              r_parity, w_parity_next;
  logic              r_tx, w_tx_next;
  logic              w_tick;

  logisim_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .CLK  (CLK),
    .RST  (RST),
    .en   (r_state != IDLE),
    .tick (w_tick)
  );

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_parity_next  = r_parity;
    case (r_state)
      IDLE: begin
        if (VALID) begin
          w_state_next   = START;
          w_shift_next   = D;
          w_parity_next  = ^D;
          w_bit_idx_next = '0;
        end
      end
      START:  if (w_tick) w_state_next = DATA;
      DATA: begin
        if (w_tick) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_idx == LAST_BIT)
            w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
          else
            w_bit_idx_next = r_bit_idx + 1'b1;
        end
      end
      PARITY: if (w_tick) w_state_next = STOP;
      STOP:   if (w_tick) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase

    // Line level for the cycle that follows this edge.
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      PARITY:  w_tx_next = w_parity_next;
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_parity  <= w_parity_next;
      r_tx      <= w_tx_next;
    end
  end

  assign READY = (r_state == IDLE);
  assign BUSY  = ~READY;
  assign TX    = r_tx;

endmodule

// File: tb/tb_logisim_uart_tx.sv
// Randomized bench for logisim_uart_tx over three parameter sets, checked
// cycle by cycle against a frame built from the serial framing rules.
module tb_logisim_uart_tx;
  import logisim_uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d_drv;
  logic       valid_drv;
  int         sel;

  int checks   = 0;
  int failures = 0;

  int cfg_dw  [3] = '{4, 4, 8};
  int cfg_cpb [3] = '{4, 4, 1};
  int cfg_pe  [3] = '{1, 0, 1};

  logic tx0, rdy0, busy0, tx1, rdy1, busy1, tx2, rdy2, busy2;
  logic tx_m, rdy_m, busy_m;

  always #5 clk = ~clk;

  logisim_uart_tx #(.DATA_W(4), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut0 (
    .CLK(clk), .RST(rst_n), .D(d_drv[3:0]), .VALID(valid_drv && sel == 0),
    .READY(rdy0), .TX(tx0), .BUSY(busy0));

  logisim_uart_tx #(.DATA_W(4), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut1 (
    .CLK(clk), .RST(rst_n), .D(d_drv[3:0]), .VALID(valid_drv && sel == 1),
    .READY(rdy1), .TX(tx1), .BUSY(busy1));

  logisim_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) u_dut2 (
    .CLK(clk), .RST(rst_n), .D(d_drv), .VALID(valid_drv && sel == 2),
    .READY(rdy2), .TX(tx2), .BUSY(busy2));

  always_comb begin
    tx_m = tx0; rdy_m = rdy0; busy_m = busy0;
    if (sel == 1) begin tx_m = tx1; rdy_m = rdy1; busy_m = busy1; end
    if (sel == 2) begin tx_m = tx2; rdy_m = rdy2; busy_m = busy2; end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s (cfg %0d): got %0h expected %0h", tag, sel, got, exp);
    end
  endtask

  // Expected line levels, one entry per clock cycle of the frame.
  task automatic build_frame(input logic [7:0] w, output bit q[$]);
    bit   lv[$];
    logic par = 1'b0;
    q = {};
    lv.push_back(1'b0);
    for (int b = 0; b < cfg_dw[sel]; b++) begin
      lv.push_back(w[b]);
      par ^= w[b];
    end
    if (cfg_pe[sel] != 0) lv.push_back(par);
    lv.push_back(1'b1);
    foreach (lv[i])
      for (int c = 0; c < cfg_cpb[sel]; c++) q.push_back(lv[i]);
  endtask

  // Called at a negedge with the selected DUT idle; returns at the negedge
  // after the frame, where the DUT must be idle again.
  task automatic xfer(input logic [7:0] w, input bit keep_valid, input logic [7:0] w_next);
    bit q[$];
    d_drv     = w;
    valid_drv = 1'b1;
    chk_eq("ready_before_accept", rdy_m, 1'b1);
    build_frame(w, q);
    @(negedge clk);
    if (keep_valid) d_drv = w_next;
    else begin
      valid_drv = 1'b0;
      d_drv     = 8'($urandom);
    end
    foreach (q[i]) begin
      chk_eq("tx_bit", tx_m, q[i]);
      chk_eq("busy_in_frame", busy_m, 1'b1);
      if (!keep_valid && i == 1) d_drv = 8'($urandom);
      @(negedge clk);
    end
    chk_eq("ready_after_frame", rdy_m, 1'b1);
    chk_eq("tx_idle_after_frame", tx_m, 1'b1);
    chk_eq("busy_after_frame", busy_m, 1'b0);
  endtask

  task automatic random_frames(input int n);
    logic [7:0] w, nw;
    bit kv;
    w = 8'($urandom);
    for (int k = 0; k < n; k++) begin
      kv = (k == n - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      nw = 8'($urandom);
      xfer(w, kv, nw);
      w = nw;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; valid_drv = 1'b0; d_drv = '0; sel = 0;
    repeat (2) @(negedge clk);

    // Reset held with VALID high: nothing may start.
    valid_drv = 1'b1; d_drv = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("rst_tx", tx_m, 1'b1);
      chk_eq("rst_ready", rdy_m, 1'b1);
      chk_eq("rst_busy", busy_m, 1'b0);
    end
    rst_n = 1'b1;
    xfer(8'h0F, 1'b0, 8'h00);

    xfer(8'h0A, 1'b0, 8'h00);
    xfer(8'h07, 1'b0, 8'h00);
    xfer(8'h03, 1'b1, 8'h0C);
    xfer(8'h0C, 1'b0, 8'h00);

    // Reset in the middle of a frame.
    d_drv = 8'h05; valid_drv = 1'b1;
    @(negedge clk);
    valid_drv = 1'b0;
    repeat (9) @(negedge clk);
    chk_eq("busy_before_midrst", busy_m, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_eq("midrst_tx", tx_m, 1'b1);
    chk_eq("midrst_ready", rdy_m, 1'b1);
    chk_eq("midrst_busy", busy_m, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("midrst_stays_idle", rdy_m, 1'b1);
    xfer(8'h09, 1'b0, 8'h00);
    random_frames(6);

    sel = 1;
    xfer(8'h07, 1'b0, 8'h00);
    random_frames(5);

    sel = 2;
    xfer(8'hA5, 1'b0, 8'h00);
    random_frames(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
